proc_bus_arbiter: RTL and testbench

//  N-master to 1-slave arbiter for the processor ready/valid bus, width-parametrised.

---
 rtl/proc_bus_arbiter_if.sv | 31 +++
 rtl/proc_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_proc_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_bus_arbiter_if.sv
// Processor ready/valid bus bundle: N request ports on one side, a single slave port on the other.
// The "master" modport drives requests and slave responses; the "slave" modport is the arbiter's view.
interface proc_bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);
  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_ready;
  logic [DATA_W-1:0]           m_rdata;
  logic [N_MASTERS-1:0]        m_err;
  logic                        s_valid;
  logic                        s_we;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic                        s_ready;
  logic [DATA_W-1:0]           s_rdata;

  modport master (
    output m_valid, m_we, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, m_err, s_valid, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_valid, m_we, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, m_err, s_valid, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/proc_bus_arbiter.sv
// Round-robin N-master to 1-slave arbiter, one transaction in flight, registered request and response.
// Optional slave-stall timeout enabled by defining PROC_ARB_TIMEOUT_EN.
module proc_bus_arbiter #(
  parameter int unsigned N_MASTERS   = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_bus_arbiter_if.slave    bus
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYC == 0) begin : g_param_chk
    $error("proc_bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_gnt;
  logic                 r_s_valid;
  logic                 r_s_we;
  logic [ADDR_W-1:0]    r_s_addr;
  logic [DATA_W-1:0]    r_s_wdata;
  logic [N_MASTERS-1:0] r_m_ready;
  logic [DATA_W-1:0]    r_m_rdata;

  logic                 w_any;
  logic [IDX_W-1:0]     w_pick;
  logic [SUM_W-1:0]     w_idx;

  // First requester at or above rr_ptr, wrapping modulo N_MASTERS.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_idx  = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      w_idx = {1'b0, r_rr_ptr} + SUM_W'(k);
      if (w_idx >= SUM_W'(N_MASTERS)) w_idx = w_idx - SUM_W'(N_MASTERS);
      if (!w_any && bus.m_valid[w_idx[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IDX_W-1:0];
      end
    end
  end

`ifdef PROC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0]     r_to_cnt;
  logic [N_MASTERS-1:0] r_m_err;
  logic                 w_to_hit;

  assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_s_valid <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_ready <= '0;
      r_m_rdata <= '0;
`ifdef PROC_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_m_err   <= '0;
`endif
    end else begin
      // Response outputs are single-cycle pulses unless re-armed below.
      r_m_ready <= '0;
      r_m_rdata <= '0;
`ifdef PROC_ARB_TIMEOUT_EN
      r_m_err   <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_pick;
            r_s_valid <= 1'b1;
            r_s_we    <= bus.m_we[w_pick];
            r_s_addr  <= bus.m_addr[w_pick*ADDR_W +: ADDR_W];
            r_s_wdata <= bus.m_wdata[w_pick*DATA_W +: DATA_W];
            r_state   <= S_WAIT;
`ifdef PROC_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (bus.s_ready) begin
            r_s_valid        <= 1'b0;
            r_m_ready[r_gnt] <= 1'b1;
            r_m_rdata        <= r_s_we ? '0 : bus.s_rdata;
            r_state          <= S_RESP;
          end
`ifdef PROC_ARB_TIMEOUT_EN
          else if (w_to_hit) begin
            r_s_valid        <= 1'b0;
            r_m_ready[r_gnt] <= 1'b1;
            r_m_err[r_gnt]   <= 1'b1;
            r_state          <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          r_rr_ptr <= (r_gnt == IDX_W'(N_MASTERS - 1)) ? '0 : r_gnt + IDX_W'(1);
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_valid = r_s_valid;
  assign bus.s_we    = r_s_we;
  assign bus.s_addr  = r_s_addr;
  assign bus.s_wdata = r_s_wdata;
  assign bus.m_ready = r_m_ready;
  assign bus.m_rdata = r_m_rdata;
`ifdef PROC_ARB_TIMEOUT_EN
  assign bus.m_err   = r_m_err;
`else
  assign bus.m_err   = '0;
`endif

endmodule

// File: tb/tb_proc_bus_arbiter.sv
// Self-checking bench for proc_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model. Timeout scenario runs only with PROC_ARB_TIMEOUT_EN defined.
module tb_proc_bus_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  proc_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Master-side request state, held until that master sees its completion.
  logic          req_v [N];
  logic          req_we[N];
  logic [AW-1:0] req_addr[N];
  logic [DW-1:0] req_wd[N];
  bit            done[N];

  // Traffic knobs; rdy_delay >= 0 selects a fixed stall, otherwise rdy_pct random.
  bit [N-1:0]    mask;
  int            req_pct, keep_pct, rdy_pct, rdy_delay;
  bit            rdata_fix_en;
  logic [DW-1:0] rdata_fix;
  bit            rst_req;
  int            run_len;
  int            grant_q[$];

  // Reference model: phase 0 = free, 1 = slave request outstanding, 2 = answering master.
  int            mdl_ph, mdl_ptr, mdl_gnt, mdl_cnt;
  bit            mdl_to, chk_en;
  logic          mdl_we;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wd, mdl_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    req_v[i]    = 1'b1;
    req_we[i]   = 1'($urandom);
    req_addr[i] = AW'($urandom);
    req_wd[i]   = DW'($urandom);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wd[i] = d; done[i] = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        done[i] = 1'b0;
        if (mask[i] && $urandom_range(99) < keep_pct) new_req(i);
        else req_v[i] = 1'b0;
      end else if (!req_v[i] && mask[i] && $urandom_range(99) < req_pct) begin
        new_req(i);
      end
      bus.m_valid[i]           = req_v[i];
      bus.m_we[i]              = req_we[i];
      bus.m_addr[i*AW +: AW]   = req_addr[i];
      bus.m_wdata[i*DW +: DW]  = req_wd[i];
    end
    if (rdy_delay >= 0) bus.s_ready = bus.s_valid && (run_len >= rdy_delay);
    else                bus.s_ready = bus.s_valid && ($urandom_range(99) < rdy_pct);
    bus.s_rdata = rdata_fix_en ? rdata_fix : DW'($urandom);
    rst = rst_req;
  endtask

  task automatic check_update();
    bit found;
    if (chk_en) begin
      chk("s_valid", 64'(bus.s_valid), 64'(mdl_ph == 1));
      chk("m_ready", 64'(bus.m_ready), (mdl_ph == 2) ? 64'(1) << mdl_gnt : 64'(0));
      chk("m_rdata", 64'(bus.m_rdata), (mdl_ph == 2) ? 64'(mdl_cap) : 64'(0));
      chk("m_err",   64'(bus.m_err),   (mdl_ph == 2 && mdl_to) ? 64'(1) << mdl_gnt : 64'(0));
      if (mdl_ph == 1) begin
        chk("s_we",    64'(bus.s_we),    64'(mdl_we));
        chk("s_addr",  64'(bus.s_addr),  64'(mdl_addr));
        chk("s_wdata", 64'(bus.s_wdata), 64'(mdl_wd));
      end
    end
    for (int i = 0; i < N; i++)
      if (bus.m_ready[i] === 1'b1) begin done[i] = 1'b1; grant_q.push_back(i); end
    run_len = (bus.s_valid === 1'b1) ? run_len + 1 : 0;

    if (rst) begin
      mdl_ph = 0; mdl_ptr = 0; chk_en = 1'b1;
    end else begin
      case (mdl_ph)
        0: begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mdl_ptr + k) % N;
            if (!found && req_v[idx]) begin
              found = 1'b1; mdl_gnt = idx;
            end
          end
          if (found) begin
            mdl_ph = 1; mdl_cnt = 0;
            mdl_we = req_we[mdl_gnt]; mdl_addr = req_addr[mdl_gnt]; mdl_wd = req_wd[mdl_gnt];
          end
        end
        1: begin
          if (bus.s_ready) begin
            mdl_cap = mdl_we ? '0 : bus.s_rdata; mdl_to = 1'b0; mdl_ph = 2;
          end
`ifdef PROC_ARB_TIMEOUT_EN
          else if (mdl_cnt + 1 == TO) begin
            mdl_cap = '0; mdl_to = 1'b1; mdl_ph = 2;
          end else begin
            mdl_cnt++;
          end
`endif
        end
        default: begin
          mdl_ptr = (mdl_gnt + 1) % N; mdl_ph = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  // Let outstanding work drain so the next cycle is an idle arbitration cycle.
  task automatic idle();
    bit busy;
    mask = '0;
    for (int c = 0; c < 400; c++) begin
      busy = (mdl_ph != 0);
      for (int i = 0; i < N; i++) if (req_v[i] && !done[i]) busy = 1'b1;
      if (!busy) break;
      step();
    end
    chk("drain_s_valid", 64'(bus.s_valid), 64'(0));
  endtask

  task automatic chk_grants(input string tag, input int g0, input int g1, input int g2, input int g3);
    int exp_g[4];
    exp_g = '{g0, g1, g2, g3};
    chk({tag, "_count"}, 64'(grant_q.size() >= 4), 64'(1));
    for (int k = 0; k < 4; k++)
      chk(tag, (k < grant_q.size()) ? 64'(grant_q[k]) : 64'(-1), 64'(exp_g[k]));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wd[i] = '0; done[i] = 1'b0;
    end
    mask = '0; req_pct = 0; keep_pct = 0; rdy_pct = 50; rdy_delay = 0;
    rdata_fix_en = 1'b0; rdata_fix = '0; rst_req = 1'b1; run_len = 0;
    mdl_ph = 0; mdl_ptr = 0; mdl_gnt = 0; mdl_cnt = 0; mdl_to = 1'b0; chk_en = 1'b0;
    mdl_we = 1'b0; mdl_addr = '0; mdl_wd = '0; mdl_cap = '0;
    bus.m_valid = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_ready = 1'b0; bus.s_rdata = '0;

    repeat (3) step();
    rst_req = 1'b0;
    step();
    chk("rst_s_valid", 64'(bus.s_valid), 64'(0));
    chk("rst_m_ready", 64'(bus.m_ready), 64'(0));

    // Single read from master 1, slave answers on the first request cycle.
    idle();
    set_req(1, 1'b0, 16'h0040, 16'h0000);
    rdy_delay = 0; rdata_fix_en = 1'b1; rdata_fix = 16'hBEEF;
    step();
    step();
    chk("t1_s_valid", 64'(bus.s_valid), 64'(1));
    chk("t1_s_addr",  64'(bus.s_addr),  64'h0040);
    chk("t1_s_we",    64'(bus.s_we),    64'(0));
    step();
    chk("t1_m_ready", 64'(bus.m_ready), 64'b0010);
    chk("t1_m_rdata", 64'(bus.m_rdata), 64'hBEEF);
    rdata_fix_en = 1'b0;

    // Write from master 2 with the slave stalling three cycles.
    idle();
    set_req(2, 1'b1, 16'h1234, 16'hA5A5);
    rdy_delay = 3;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_s_valid", 64'(bus.s_valid), 64'(1));
      chk("t3_s_addr",  64'(bus.s_addr),  64'h1234);
      chk("t3_s_wdata", 64'(bus.s_wdata), 64'hA5A5);
    end
    step();
    chk("t3_m_ready", 64'(bus.m_ready), 64'b0100);
    chk("t3_s_valid_drop", 64'(bus.s_valid), 64'(0));

    // Reset while the slave request is outstanding; pointer returns to 0.
    idle();
    rdy_delay = 1000;
    set_req(1, 1'b0, 16'h1111, 16'h0000);
    set_req(3, 1'b0, 16'h3333, 16'h0000);
    step();
    step();
    chk("t4_first_addr", 64'(bus.s_addr), 64'h3333);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("t4_s_valid", 64'(bus.s_valid), 64'(0));
    chk("t4_m_ready", 64'(bus.m_ready), 64'(0));
    step();
    chk("t4_regrant_addr", 64'(bus.s_addr), 64'h1111);
    rdy_delay = 0;
    idle();

    // All four masters request continuously from reset.
    rst_req = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin set_req(i, 1'(i), AW'(16'h0100 * i), DW'(i)); end
    mask = 4'b1111; req_pct = 100; keep_pct = 100; rdy_delay = -1; rdy_pct = 50;
    rst_req = 1'b0;
    grant_q.delete();
    repeat (60) step();
    chk_grants("t2_order", 0, 1, 2, 3);
    chk("t2_order5", (grant_q.size() > 4) ? 64'(grant_q[4]) : 64'(-1), 64'(0));
    idle();

    // Masters 0 and 3 both keep requesting; grants must alternate.
    rst_req = 1'b1;
    step();
    set_req(0, 1'b0, 16'h0A00, 16'h0000);
    set_req(3, 1'b1, 16'h0A03, 16'h5A5A);
    mask = 4'b1001; req_pct = 100; keep_pct = 100;
    rst_req = 1'b0;
    grant_q.delete();
    repeat (60) step();
    chk_grants("t6_alt", 0, 3, 0, 3);
    idle();

`ifdef PROC_ARB_TIMEOUT_EN
    // Slave never answers: request times out after TO cycles with an error.
    begin
      int sv_cycles;
      sv_cycles = 0;
      set_req(1, 1'b0, 16'h0777, 16'h0000);
      rdy_delay = 1000;
      step();
      for (int c = 0; c < 3 * TO; c++) begin
        step();
        if (bus.s_valid !== 1'b1) break;
        sv_cycles++;
      end
      chk("t5_sv_cycles", 64'(sv_cycles), 64'(TO));
      chk("t5_m_ready",   64'(bus.m_ready), 64'b0010);
      chk("t5_m_err",     64'(bus.m_err),   64'b0010);
      chk("t5_m_rdata",   64'(bus.m_rdata), 64'(0));
      rdy_delay = 0;
      idle();
    end
`endif

    // Random traffic with occasional resets, all checked by the model.
    mask = 4'b1111; req_pct = 30; keep_pct = 50; rdy_delay = -1; rdy_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      rst_req = ($urandom_range(199) == 0);
      step();
    end
    rst_req = 1'b0;
    rdy_delay = 0;
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
